// File: rtl/arb_pkg.sv
// Shared types and the rotating-priority pick used by the four-client arbiter.
package arb_pkg;

  localparam int N_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // First set bit at or above start, wrapping 3->0; returns start when req is empty.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = start;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/decoder_2_4.sv
// 2-to-4 enable decoder: one-hot bcode selected by a while en is high, zero otherwise.
module decoder_2_4 (
  input  logic       en,
  input  logic [1:0] a,
  output logic [3:0] bcode
);

  assign bcode = en ? (4'b0001 << a) : 4'b0000;

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-client round-robin arbiter with ownership hold and optional hold timeout.
// The winner index is registered; the one-hot grant is decoded from registered state only.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       grant_valid,
  output logic [1:0] grant_id
);

  localparam int CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam bit TIMEOUT_EN = (MAX_HOLD != 0);

  arb_state_t    state_q,    state_d;
  logic [1:0]    grant_id_q, grant_id_d;
  logic [1:0]    ptr_q,      ptr_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;

  logic [3:0] others;
  logic [1:0] next_ptr;

  assign others   = req & ~(4'b0001 << grant_id_q);
  assign next_ptr = grant_id_q + 2'd1;

  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = GRANT;
          grant_id_d = rr_pick(req, ptr_q);
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (!req[grant_id_q]) begin
          ptr_d = next_ptr;
          if (|others) begin
            grant_id_d = rr_pick(others, next_ptr);
            hold_cnt_d = '0;
          end else begin
            state_d    = IDLE;
            grant_id_d = 2'd0;
            hold_cnt_d = '0;
          end
        end else if (TIMEOUT_EN && (hold_cnt_q == HOLD_LAST) && (|others)) begin
          ptr_d      = next_ptr;
          grant_id_d = rr_pick(others, next_ptr);
          hold_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_id_q <= 2'd0;
      ptr_q      <= 2'd0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign grant_valid = (state_q == GRANT);
  assign grant_id    = grant_id_q;

  decoder_2_4 u_dec (
    .en    (grant_valid),
    .a     (grant_id_q),
    .bcode (grant)
  );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4 (MAX_HOLD=8): a per-cycle comparison against an
// ownership model plus literal expectations from the hand-worked scenarios.
module tb_rr_arbiter_4;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;

  int n_vec  = 0;
  int n_miss = 0;

  rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  // Model: owner is -1 when idle; tenure counts cycles owned beyond the first.
  int m_owner  = -1;
  int m_ptr    = 0;
  int m_tenure = 0;

  function automatic int closest(input logic [3:0] r, input int start);
    int best = -1;
    int best_dist = 99;
    for (int i = 0; i < 4; i++) begin
      if (r[i] && ((i - start + 4) % 4) < best_dist) begin
        best_dist = (i - start + 4) % 4;
        best = i;
      end
    end
    return best;
  endfunction

  always @(posedge clk) begin
    logic [3:0] rest;
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_tenure = 0;
    end else if (m_owner < 0) begin
      if (req != 4'b0000) begin
        m_owner = closest(req, m_ptr); m_tenure = 0;
      end
    end else begin
      rest = req;
      rest[m_owner] = 1'b0;
      if (!req[m_owner]) begin
        m_ptr = (m_owner + 1) % 4;
        m_owner = (rest != 4'b0000) ? closest(rest, m_ptr) : -1;
        m_tenure = 0;
      end else if (MAX_HOLD != 0 && m_tenure >= MAX_HOLD - 1 && rest != 4'b0000) begin
        m_ptr = (m_owner + 1) % 4;
        m_owner = closest(rest, m_ptr);
        m_tenure = 0;
      end else begin
        m_tenure++;
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  bit model_on = 1'b0;

  always @(negedge clk) begin
    logic [3:0] eg;
    if (model_on) begin
      eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      check("model_grant", {4'b0, grant}, {4'b0, eg});
      check("model_valid", {7'b0, grant_valid}, {7'b0, (m_owner >= 0)});
      check("model_id", {6'b0, grant_id}, (m_owner < 0) ? 8'd0 : 8'(m_owner));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b1111;
    tick();
    model_on = 1'b1;

    // Reset held with all requesting.
    for (int i = 0; i < 3; i++) begin
      check("rst_grant", {4'b0, grant}, 8'b0000_0000);
      check("rst_valid", {7'b0, grant_valid}, 8'd0);
      check("rst_id", {6'b0, grant_id}, 8'd0);
      tick();
    end
    reset = 1'b0;
    tick();
    check("post_rst_grant", {4'b0, grant}, 8'b0000_0001);
    req = 4'b0000; tick();
    check("idle_after_drop", {4'b0, grant}, 8'b0000_0000);

    // Single requester.
    req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("single_grant", {4'b0, grant}, 8'b0000_0100);
    end
    req = 4'b0000; tick();
    check("single_idle", {4'b0, grant}, 8'b0000_0000);

    // Handoff without a bubble, then wrap of the pointer.
    pulse_reset();
    req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("handoff_c1", {4'b0, grant}, 8'b0000_0010);
    end
    req = 4'b1000; tick();
    check("handoff_c3", {4'b0, grant}, 8'b0000_1000);
    req = 4'b1011; tick();
    check("c3_keeps", {4'b0, grant}, 8'b0000_1000);
    req = 4'b0011; tick();
    check("wrap_to_c0", {4'b0, grant}, 8'b0000_0001);
    req = 4'b0000; tick();

    // Timeout rotation with everyone requesting.
    pulse_reset();
    req = 4'b1111;
    for (int k = 0; k < 40; k++) begin
      tick();
      check("rotate_id", {6'b0, grant_id}, 8'((k / MAX_HOLD) % 4));
    end
    req = 4'b0000; tick();

    // Lone owner saturates, then a newcomer preempts immediately.
    req = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("lone_owner", {4'b0, grant}, 8'b0000_0001);
    end
    req = 4'b0101; tick();
    check("sat_preempt", {4'b0, grant}, 8'b0000_0100);
    req = 4'b0000; tick();

    // Reset in the middle of a grant.
    req = 4'b1000;
    tick(); tick();
    check("pre_rst_grant", {4'b0, grant}, 8'b0000_1000);
    reset = 1'b1; tick();
    check("mid_rst_grant", {4'b0, grant}, 8'b0000_0000);
    reset = 1'b0; tick();
    check("regrant", {4'b0, grant}, 8'b0000_1000);
    req = 4'b0000; tick(); tick();

    @(posedge clk);
    model_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
